// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time inserter: phase FSM encoding and
// the dead-time limits used for parameter checking.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_DT_LOW  = 3'd1,
        ST_LOW     = 3'd2,
        ST_DT_HIGH = 3'd3,
        ST_HIGH    = 3'd4
    } phase_state_t;

    localparam int DEADTIME_DEFAULT = 50;
    localparam int DEADTIME_MIN     = 1;
    localparam int DEADTIME_MAX     = 255;

    function automatic bit deadtime_legal(input int dt);
        return (dt >= DEADTIME_MIN) && (dt <= DEADTIME_MAX);
    endfunction

endpackage

// File: rtl/pwm_deadtime_phase.sv
// One half-bridge: input register, five-state dead-time FSM and dead-time
// counter. Gate drives decode from the state register only.
module pwm_deadtime_phase
    import pwm_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iRun,
    input  logic iPWM,
    output logic oHigh,
    output logic oLow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEADTIME - 1);

    logic             in_q;
    phase_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= iPWM;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Dead-time states restart on any input reversal, so short pulses are swallowed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!iRun) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = in_q ? ST_DT_HIGH : ST_DT_LOW;
                    cnt_nxt   = '0;
                end
                ST_LOW: begin
                    if (in_q) begin
                        state_nxt = ST_DT_HIGH;
                        cnt_nxt   = '0;
                    end
                end
                ST_HIGH: begin
                    if (!in_q) begin
                        state_nxt = ST_DT_LOW;
                        cnt_nxt   = '0;
                    end
                end
                ST_DT_HIGH: begin
                    if (!in_q) begin
                        state_nxt = ST_DT_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_DT_LOW: begin
                    if (in_q) begin
                        state_nxt = ST_DT_HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign oHigh = (state == ST_HIGH);
    assign oLow  = (state == ST_LOW);

endmodule

// File: rtl/pwm_deadtime_insert.sv
// Three-phase PWM dead-time inserter with fault shutdown.
// Define PWM_DT_FAULT_LATCH_EN to latch faults until iFault_clr.
module pwm_deadtime_insert
    import pwm_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iPWM_u,
    input  logic iPWM_v,
    input  logic iPWM_w,
    input  logic iFault,
    input  logic iFault_clr,
    output logic oPWM_uh,
    output logic oPWM_ul,
    output logic oPWM_vh,
    output logic oPWM_vl,
    output logic oPWM_wh,
    output logic oPWM_wl,
    output logic oFault
);

    if (!deadtime_legal(DEADTIME)) begin : g_bad_deadtime
        $error("pwm_deadtime_insert: DEADTIME=%0d outside %0d..%0d",
               DEADTIME, DEADTIME_MIN, DEADTIME_MAX);
    end
    if ((DEADTIME - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("pwm_deadtime_insert: CNT_W=%0d too narrow for DEADTIME=%0d",
               CNT_W, DEADTIME);
    end

    logic fault_q;
    logic run;

`ifdef PWM_DT_FAULT_LATCH_EN
    // A simultaneous fault and clear keeps the latch set.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fault_q <= 1'b0;
        end else if (iFault) begin
            fault_q <= 1'b1;
        end else if (iFault_clr) begin
            fault_q <= 1'b0;
        end
    end
`else
    logic fault_clr_unused;
    assign fault_clr_unused = iFault_clr;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= iFault;
        end
    end
`endif

    assign oFault = fault_q;
    assign run    = iEn & ~fault_q;

    pwm_deadtime_phase #(.DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_phase_u (
        .iClk (iClk),
        .iRst (iRst),
        .iRun (run),
        .iPWM (iPWM_u),
        .oHigh(oPWM_uh),
        .oLow (oPWM_ul)
    );

    pwm_deadtime_phase #(.DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_phase_v (
        .iClk (iClk),
        .iRst (iRst),
        .iRun (run),
        .iPWM (iPWM_v),
        .oHigh(oPWM_vh),
        .oLow (oPWM_vl)
    );

    pwm_deadtime_phase #(.DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_phase_w (
        .iClk (iClk),
        .iRst (iRst),
        .iRun (run),
        .iPWM (iPWM_w),
        .oHigh(oPWM_wh),
        .oLow (oPWM_wl)
    );

endmodule
